add_acc_ctrl: RTL

Frame accumulator that sequences operands into the 16-bit combinational adder and consumes its result. It accepts a valid/ready stream of 16-bit unsigned words, drives the running sum and the incoming word onto the adder's `a`/`b` inputs, and registers the adder's `result` as the new running sum. At end of frame it presents the modulo-2^16 frame sum, a sticky carry-out flag and a beat count on a valid/ready output port.

---
 rtl/add_acc_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/add_acc_ctrl.sv
// add_acc_ctrl: frame accumulator that feeds an external 16-bit adder.
// Each accepted word is added to the running sum. At end of frame the block
// holds the sum, a sticky carry flag and a saturating beat count on a
// valid/ready output port.

module add_acc_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q;
  logic             first_q;
  logic [15:0]      acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             outValid_q;
  logic [15:0]      outSum_q;
  logic [CNT_W-1:0] outCnt_q;
  logic             outOvf_q;

  logic             carry;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_d;

  // The first beat of a frame adds to zero so no clear cycle is needed.
  assign add_a = first_q ? 16'h0000 : acc_q;
  assign add_b = in_data;

  assign in_ready  = (state_q == ACC);
  assign out_valid = outValid_q;
  assign out_sum   = outSum_q;
  assign out_ovf   = outOvf_q;
  assign out_cnt   = outCnt_q;

  // Per-beat count and overflow updates, shared by mid-frame and last beats.
  always_comb begin
    carry = 1'b0;
    cnt_d = '0;
    ovf_d = 1'b0;
    carry = (add_result < add_a);
    if (first_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    ovf_d = (first_q ? 1'b0 : ovf_q) | carry;
  end

  // Frame FSM: accumulate in ACC, hold the registered result in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACC;
      first_q    <= 1'b1;
      acc_q      <= 16'h0000;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
      outSum_q   <= 16'h0000;
      outCnt_q   <= '0;
      outOvf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (in_valid) begin
            if (!in_last) begin
              acc_q   <= add_result;
              cnt_q   <= cnt_d;
              ovf_q   <= ovf_d;
              first_q <= 1'b0;
            end else begin
              outSum_q   <= add_result;
              outCnt_q   <= cnt_d;
              outOvf_q   <= ovf_d;
              outValid_q <= 1'b1;
              first_q    <= 1'b1;
              state_q    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= ACC;
          end
        end
        default: begin
          state_q <= ACC;
        end
      endcase
    end
  end

endmodule
